// File: rtl/alarm_clock_pkg.sv
// Shared types, constants and helpers for the multi-alarm clock.
// Provides the ring FSM state enum, edit-field codes, the alarm record,
// field wrap limits, binary->BCD conversion and the 7-segment decoder.
package alarm_clock_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_e;
  typedef enum logic [1:0] {FLD_NONE, FLD_HOUR, FLD_MIN, FLD_SEC} field_e;

  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
  } alarm_t;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;
  localparam logic [6:0] SEG_ZERO   = 7'b1000000;

  // Active-low {g..a} pattern for one decimal digit; blank for non-digits.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Increment/decrement with wrap between 0 and max_v.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v >= max_v) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  // {tens, units} of a value below 70 by repeated subtraction.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] u;
    logic [3:0] t;
    u = v;
    t = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (u >= 6'd10) begin
        u = u - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, 4'(u)};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low push-button conditioner: 2-FF synchroniser followed by a
// stability counter. Press pulses for one cycle when a 1->0 level change
// has been stable for DEBOUNCE_CYC cycles.
//   Clk_50MHz : clock          Rst   : async reset, active-high
//   BtnN      : raw button     Press : one-cycle accepted-press pulse
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic Clk_50MHz,
  input  logic Rst,
  input  logic BtnN,
  output logic Press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             stable_q, stable_d, press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count while the synchronised level differs from the accepted one.
  always_comb begin
    sync1_d  = BtnN;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q >= CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk_50MHz or posedge Rst) begin
    if (Rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Press = press_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// HH:MM:SS clock with NUM_ALARMS HH:MM alarms, button editing, accelerated
// tick, ring/snooze FSM and six registered 7-segment digits.
//   Clk_50MHz, Rst          : clock, async active-high reset
//   Up/Down/Snooze          : active-low buttons
//   Accel                   : fast tick select
//   Sw, AlmEdit, AlmSel     : edit mode, field select, alarm target
//   AlmEn                   : per-alarm enable
//   Seg6..Seg1              : active-low digits (hour, min, sec)
//   Led, ALed               : ringing indicator, triggering-alarm flags
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter  int unsigned CLK_HZ       = 50_000_000,
  parameter  int unsigned ACCEL_DIV    = 1000,
  parameter  int unsigned NUM_ALARMS   = 4,
  parameter  int unsigned DEBOUNCE_CYC = 500_000,
  parameter  int unsigned RING_SEC     = 60,
  parameter  int unsigned SNOOZE_SEC   = 300,
  localparam int unsigned SEL_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  Clk_50MHz,
  input  logic                  Rst,
  input  logic                  Up,
  input  logic                  Down,
  input  logic                  Snooze,
  input  logic                  Accel,
  input  logic [3:0]            Sw,
  input  logic                  AlmEdit,
  input  logic [SEL_W-1:0]      AlmSel,
  input  logic [NUM_ALARMS-1:0] AlmEn,
  output logic [6:0]            Seg6,
  output logic [6:0]            Seg5,
  output logic [6:0]            Seg4,
  output logic [6:0]            Seg3,
  output logic [6:0]            Seg2,
  output logic [6:0]            Seg1,
  output logic                  Led,
  output logic [NUM_ALARMS-1:0] ALed
);

  localparam int unsigned PRE_W    = $clog2(CLK_HZ + 1);
  localparam int unsigned FAST_DIV = (CLK_HZ / ACCEL_DIV > 0) ? CLK_HZ / ACCEL_DIV : 1;
  localparam int unsigned CNT_MAX  = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  logic up_p, dn_p, sn_p;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (
    .Clk_50MHz(Clk_50MHz), .Rst(Rst), .BtnN(Up), .Press(up_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_down (
    .Clk_50MHz(Clk_50MHz), .Rst(Rst), .BtnN(Down), .Press(dn_p));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_snooze (
    .Clk_50MHz(Clk_50MHz), .Rst(Rst), .BtnN(Snooze), .Press(sn_p));

  logic [PRE_W-1:0]      pre_q, pre_d, div_m1_c;
  logic                  accel_q, accel_d, sw0_q, sw0_d;
  logic [4:0]            hh_q, hh_d;
  logic [5:0]            mm_q, mm_d, ss_q, ss_d;
  alarm_t                alm_q [NUM_ALARMS];
  alarm_t                alm_d [NUM_ALARMS];
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  led_q, led_d;
  logic [NUM_ALARMS-1:0] aled_q, aled_d, match_c;
  logic [5:0][6:0]       seg_q, seg_d;

  logic   freeze_c, tick_c, step_c, sel_ok_c, show_alm_c;
  field_e field_c;
  logic [5:0] disp_h_c, disp_m_c, disp_s_c;
  logic [7:0] bcd_h_c, bcd_m_c, bcd_s_c;

  assign freeze_c = Sw[0] & ~AlmEdit;
  assign sel_ok_c = 32'(AlmSel) < NUM_ALARMS;
  assign div_m1_c = Accel ? PRE_W'(FAST_DIV - 1) : PRE_W'(CLK_HZ - 1);
  assign accel_d  = Accel;
  assign sw0_d    = Sw[0];

  // Field select is valid only in edit mode with exactly one field bit set.
  always_comb begin
    field_c = FLD_NONE;
    if (Sw[0]) begin
      case (Sw[3:1])
        3'b001:  field_c = FLD_HOUR;
        3'b010:  field_c = FLD_MIN;
        3'b100:  field_c = FLD_SEC;
        default: field_c = FLD_NONE;
      endcase
    end
  end

  // Simultaneous Up and Down cancel out.
  assign step_c = (field_c != FLD_NONE) & (up_p ^ dn_p);

  // Tick prescaler; an Accel change restarts the period.
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    tick_c = 1'b0;
    if (freeze_c || (Accel != accel_q)) begin
      pre_d = '0;
    end else if (pre_q >= div_m1_c) begin
      pre_d  = '0;
      tick_c = 1'b1;
    end
  end

  // Time counting and time edit (mutually exclusive: edit freezes the tick).
  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (tick_c) begin
      ss_d = wrap_step(ss_q, MINSEC_MAX, 1'b1);
      if (ss_q == MINSEC_MAX) begin
        mm_d = wrap_step(mm_q, MINSEC_MAX, 1'b1);
        if (mm_q == MINSEC_MAX) hh_d = 5'(wrap_step(6'(hh_q), 6'(HOUR_MAX), 1'b1));
      end
    end else if (step_c && !AlmEdit) begin
      case (field_c)
        FLD_HOUR: begin
          hh_d = 5'(wrap_step(6'(hh_q), 6'(HOUR_MAX), up_p));
          ss_d = '0;
        end
        FLD_MIN: begin
          mm_d = wrap_step(mm_q, MINSEC_MAX, up_p);
          ss_d = '0;
        end
        FLD_SEC: ss_d = wrap_step(ss_q, MINSEC_MAX, up_p);
        default: ;
      endcase
    end
  end

  // Alarm edit; alarms have no seconds field.
  always_comb begin
    alm_d = alm_q;
    if (step_c && AlmEdit && sel_ok_c) begin
      case (field_c)
        FLD_HOUR: alm_d[AlmSel].hh = 5'(wrap_step(6'(alm_q[AlmSel].hh), 6'(HOUR_MAX), up_p));
        FLD_MIN:  alm_d[AlmSel].mm = wrap_step(alm_q[AlmSel].mm, MINSEC_MAX, up_p);
        default: ;
      endcase
    end
  end

  // A match is evaluated against the time the rollover tick produces.
  for (genvar k = 0; k < int'(NUM_ALARMS); k++) begin : g_match
    assign match_c[k] = tick_c && (ss_q == MINSEC_MAX) && AlmEn[k] &&
                        (alm_q[k].hh == hh_d) && (alm_q[k].mm == mm_d);
  end

  // Ring/snooze control; entering edit mode overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aled_d  = aled_q;
    if (Sw[0] && !sw0_q) begin
      state_d = ST_IDLE;
      aled_d  = '0;
    end else if (|match_c) begin
      state_d = ST_RING;
      cnt_d   = CNT_W'(RING_SEC);
      aled_d  = aled_q | match_c;
    end else begin
      case (state_q)
        ST_RING: begin
          if (sn_p) begin
            state_d = ST_SNOOZE;
            cnt_d   = CNT_W'(SNOOZE_SEC);
          end else if (dn_p || (tick_c && cnt_q <= CNT_W'(1))) begin
            state_d = ST_IDLE;
            aled_d  = '0;
          end else if (tick_c) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SNOOZE: begin
          if (dn_p) begin
            state_d = ST_IDLE;
            aled_d  = '0;
          end else if (tick_c && cnt_q <= CNT_W'(1)) begin
            state_d = ST_RING;
            cnt_d   = CNT_W'(RING_SEC);
          end else if (tick_c) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    led_d = (state_d == ST_RING);
  end

  // Display source selection and digit decode.
  always_comb begin
    show_alm_c = Sw[0] & AlmEdit & sel_ok_c;
    disp_h_c   = 6'(hh_q);
    disp_m_c   = mm_q;
    disp_s_c   = ss_q;
    if (show_alm_c) begin
      disp_h_c = 6'(alm_q[AlmSel].hh);
      disp_m_c = alm_q[AlmSel].mm;
      disp_s_c = '0;
    end
    bcd_h_c  = to_bcd(disp_h_c);
    bcd_m_c  = to_bcd(disp_m_c);
    bcd_s_c  = to_bcd(disp_s_c);
    seg_d[5] = seg7(bcd_h_c[7:4]);
    seg_d[4] = seg7(bcd_h_c[3:0]);
    seg_d[3] = seg7(bcd_m_c[7:4]);
    seg_d[2] = seg7(bcd_m_c[3:0]);
    seg_d[1] = seg7(bcd_s_c[7:4]);
    seg_d[0] = seg7(bcd_s_c[3:0]);
  end

  always_ff @(posedge Clk_50MHz or posedge Rst) begin
    if (Rst) begin
      pre_q   <= '0;
      accel_q <= 1'b0;
      sw0_q   <= 1'b0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      for (int k = 0; k < int'(NUM_ALARMS); k++) alm_q[k] <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      aled_q  <= '0;
      seg_q   <= {6{SEG_ZERO}};
    end else begin
      pre_q   <= pre_d;
      accel_q <= accel_d;
      sw0_q   <= sw0_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      alm_q   <= alm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      aled_q  <= aled_d;
      seg_q   <= seg_d;
    end
  end

  assign Seg6 = seg_q[5];
  assign Seg5 = seg_q[4];
  assign Seg4 = seg_q[3];
  assign Seg3 = seg_q[2];
  assign Seg2 = seg_q[1];
  assign Seg1 = seg_q[0];
  assign Led  = led_q;
  assign ALed = aled_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with small timing parameters.
// Ticks are placed deterministically: Accel idles at 0 (100-cycle period)
// and each tick burst raises Accel, so the first tick lands 11 edges later
// and further ticks every 10 edges. Button presses end by toggling Accel to
// restart the slow prescaler so no stray tick occurs between bursts.
module tb_multi_alarm_clock;

  localparam int unsigned CLK_HZ       = 100;
  localparam int unsigned ACCEL_DIV    = 10;
  localparam int unsigned NUM_ALARMS   = 4;
  localparam int unsigned DEBOUNCE_CYC = 4;
  localparam int unsigned RING_SEC     = 3;
  localparam int unsigned SNOOZE_SEC   = 5;

  localparam int BTN_UP = 1, BTN_DN = 2, BTN_SN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_n = 1'b1, dn_n = 1'b1, sn_n = 1'b1;
  logic       accel = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic       alm_edit = 1'b0;
  logic [1:0] alm_sel = 2'd0;
  logic [3:0] alm_en = 4'b0000;
  logic [6:0] seg6, seg5, seg4, seg3, seg2, seg1;
  logic       led;
  logic [3:0] aled;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_alarm_clock #(
    .CLK_HZ(CLK_HZ), .ACCEL_DIV(ACCEL_DIV), .NUM_ALARMS(NUM_ALARMS),
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .Clk_50MHz(clk), .Rst(rst), .Up(up_n), .Down(dn_n), .Snooze(sn_n),
    .Accel(accel), .Sw(sw), .AlmEdit(alm_edit), .AlmSel(alm_sel), .AlmEn(alm_en),
    .Seg6(seg6), .Seg5(seg5), .Seg4(seg4), .Seg3(seg3), .Seg2(seg2), .Seg1(seg1),
    .Led(led), .ALed(aled)
  );

  function automatic logic [6:0] bseg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] exp_disp(input int h, input int m, input int s);
    return {bseg(h / 10), bseg(h % 10), bseg(m / 10), bseg(m % 10), bseg(s / 10), bseg(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp_now(input string tag, input int h, input int m, input int s);
    chk(tag, 64'({seg6, seg5, seg4, seg3, seg2, seg1}), 64'(exp_disp(h, m, s)));
  endtask

  task automatic chk_disp(input string tag, input int h, input int m, input int s);
    @(posedge clk); #1;
    chk_disp_now(tag, h, m, s);
  endtask

  // Hold the selected buttons low 10 cycles, release, then restart prescaler.
  task automatic press(input int mask);
    if ((mask & BTN_UP) != 0) up_n = 1'b0;
    if ((mask & BTN_DN) != 0) dn_n = 1'b0;
    if ((mask & BTN_SN) != 0) sn_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    up_n = 1'b1; dn_n = 1'b1; sn_n = 1'b1;
    repeat (8) @(posedge clk);
    #1; accel = 1'b1;
    @(posedge clk); #1; accel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic press_n(input int mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  // Run exactly n ticks; returns #1 after the edge of the last one.
  task automatic ticks(input int n);
    accel = 1'b0;
    @(posedge clk); #1;
    accel = 1'b1;
    repeat (1 + 10 * n) @(posedge clk);
    #1; accel = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_disp_now("rst_seg", 0, 0, 0);
    chk("rst_led", 64'(led), 64'(0));
    chk("rst_aled", 64'(aled), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: preload 23:59:59, one tick wraps to 00:00:00
    sw = 4'b0011; press(BTN_DN);
    sw = 4'b0101; press(BTN_DN);
    sw = 4'b1001; press(BTN_DN);
    chk_disp("t1_preload", 23, 59, 59);
    sw = 4'b0000;
    ticks(1);
    chk_disp_now("t1_lag", 23, 59, 59);
    chk_disp("t1_wrap", 0, 0, 0);

    // 2: field wrap, invalid field select, edit disabled
    sw = 4'b0011; press(BTN_DN);
    chk_disp("t2_hr_dn", 23, 0, 0);
    press(BTN_UP);
    chk_disp("t2_hr_wrap", 0, 0, 0);
    sw = 4'b0101; press(BTN_DN);
    chk_disp("t2_min_wrap", 0, 59, 0);
    sw = 4'b0111; press(BTN_UP);
    chk_disp("t2_twofield", 0, 59, 0);
    sw = 4'b0010; press(BTN_UP);
    chk_disp("t2_noedit", 0, 59, 0);

    // 3: debounce glitch, single accepted press, Up+Down together
    sw = 4'b0011;
    up_n = 1'b0;
    repeat (3) @(posedge clk);
    #1; up_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk_disp("t3_glitch", 0, 59, 0);
    press(BTN_UP);
    chk_disp("t3_one", 1, 59, 0);
    press(BTN_UP | BTN_DN);
    chk_disp("t3_updn", 1, 59, 0);

    // 4: alarm 2 = 07:30, ring for RING_SEC ticks
    alm_edit = 1'b1; alm_sel = 2'd2;
    chk_disp("t4_alm_init", 0, 0, 0);
    press_n(BTN_UP, 7);
    sw = 4'b0101; press_n(BTN_DN, 30);
    chk_disp("t4_alm_set", 7, 30, 0);
    sw = 4'b1001; press(BTN_UP);
    chk_disp("t4_alm_sec", 7, 30, 0);
    alm_sel = 2'd1;
    chk_disp("t4_alm1", 0, 0, 0);
    alm_sel = 2'd2;
    alm_edit = 1'b0;
    sw = 4'b0011; press_n(BTN_UP, 6);
    sw = 4'b0101; press_n(BTN_DN, 30);
    sw = 4'b1001; press(BTN_DN);
    chk_disp("t4_time", 7, 29, 59);
    alm_en = 4'b0100;
    sw = 4'b0000;
    ticks(1);
    chk("t4_led", 64'(led), 64'(1));
    chk("t4_aled", 64'(aled), 64'(4'b0100));
    ticks(2);
    chk("t4_still", 64'(led), 64'(1));
    ticks(1);
    chk("t4_stop_led", 64'(led), 64'(0));
    chk("t4_stop_aled", 64'(aled), 64'(0));

    // 5: snooze then re-ring, then dismiss with Down
    sw = 4'b0101; press(BTN_DN);
    sw = 4'b1001; press(BTN_DN);
    chk_disp("t5_time", 7, 29, 59);
    sw = 4'b0000;
    ticks(1);
    chk("t5_ring", 64'(led), 64'(1));
    press(BTN_SN);
    chk("t5_snz_led", 64'(led), 64'(0));
    chk("t5_snz_aled", 64'(aled), 64'(4'b0100));
    ticks(4);
    chk("t5_snz4", 64'(led), 64'(0));
    ticks(1);
    chk("t5_rering", 64'(led), 64'(1));
    press(BTN_DN);
    chk("t5_dis_led", 64'(led), 64'(0));
    chk("t5_dis_aled", 64'(aled), 64'(0));

    // 6: async reset while ringing with Accel=1
    sw = 4'b0101; press(BTN_DN);
    sw = 4'b1001; press(BTN_DN);
    sw = 4'b0000;
    ticks(1);
    chk("t6_ring", 64'(led), 64'(1));
    accel = 1'b1;
    repeat (3) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("t6_rst_led", 64'(led), 64'(0));
    chk("t6_rst_aled", 64'(aled), 64'(0));
    chk_disp_now("t6_rst_seg", 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_disp_now("t6_hold", 0, 0, 0);
    @(posedge clk); #1;
    accel = 1'b0;
    chk_disp("t6_resume", 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
